// File: rtl/tx_sched.sv
// Two-requester transmit scheduler: arbitrates A/B codewords, strobes the serializer and paces frames.
// Define TX_SCHED_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module tx_sched #(
    parameter int FRAME_LEN = 17,
    parameter int GAP_LEN   = 0
) (
    input  logic        clk_sch,
    input  logic        rst_n_sch,
    input  logic        req_a_sch,
    input  logic [14:0] data_a_sch,
    output logic        gnt_a_sch,
    input  logic        req_b_sch,
    input  logic [14:0] data_b_sch,
    output logic        gnt_b_sch,
    output logic        enable_sch,
    output logic [14:0] msg_sch,
    output logic        busy_sch,
    output logic        done_sch,
    output logic        src_sch
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    localparam logic [4:0] SEND_LAST = 5'(FRAME_LEN - 1);
    localparam logic [4:0] GAP_LAST  = 5'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
`ifndef TX_SCHED_FIXED_PRIO_EN
    logic       prio_b;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        gnt_a_sch  = 1'b0;
        gnt_b_sch  = 1'b0;
        enable_sch = 1'b0;
        done_sch   = 1'b0;
        case (state)
            IDLE: begin
                // grants are held off while reset is asserted, even though the state reads IDLE
                if (rst_n_sch) begin
`ifdef TX_SCHED_FIXED_PRIO_EN
                    gnt_a_sch = req_a_sch;
`else
                    gnt_a_sch = req_a_sch && (!req_b_sch || !prio_b);
`endif
                    gnt_b_sch = req_b_sch && !gnt_a_sch;
                end
                if (gnt_a_sch || gnt_b_sch) state_nxt = LOAD;
            end
            LOAD: begin
                enable_sch = 1'b1;
                cnt_nxt    = '0;
                state_nxt  = SEND;
            end
            SEND: begin
                if (cnt == SEND_LAST) begin
                    done_sch = 1'b1;
                    cnt_nxt  = '0;
                    if (GAP_LEN > 0) state_nxt = GAP;
                    else             state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_sch = (state != IDLE);

    always_ff @(posedge clk_sch or negedge rst_n_sch) begin
        if (!rst_n_sch) begin
            state   <= IDLE;
            cnt     <= '0;
            msg_sch <= '0;
            src_sch <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (gnt_a_sch) begin
                msg_sch <= data_a_sch;
                src_sch <= 1'b0;
            end else if (gnt_b_sch) begin
                msg_sch <= data_b_sch;
                src_sch <= 1'b1;
            end
        end
    end

`ifndef TX_SCHED_FIXED_PRIO_EN
    // prio_b set means B wins the next tie
    always_ff @(posedge clk_sch or negedge rst_n_sch) begin
        if (!rst_n_sch)     prio_b <= 1'b0;
        else if (gnt_a_sch) prio_b <= 1'b1;
        else if (gnt_b_sch) prio_b <= 1'b0;
    end
`endif
endmodule
